// File: rtl/run_det_pkg.sv
// Shared types and helpers for the run-length detector.
// Holds the FSM state encoding and the saturating increment used by every counter.
package run_det_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_RUN0,
        RD_RUN1
    } rd_state_t;

    // Widest counter the shared helper supports; callers zero-extend into it.
    localparam int RD_MAX_W = 16;

    function automatic logic [RD_MAX_W-1:0] sat_inc(
        input logic [RD_MAX_W-1:0] cnt,
        input logic [RD_MAX_W-1:0] max_val
    );
        return (cnt >= max_val) ? max_val : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating counter with clear / load-1 / increment / hold, priority in that order.
// cnt_next is exported so the parent can derive registered flags on the same edge.
module sat_counter
    import run_det_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    if (W < 1 || W > RD_MAX_W) begin : g_bad_width
        $fatal(1, "sat_counter: W out of range");
    end

    always_comb begin
        cnt_next = cnt;
        if (clr) begin
            cnt_next = '0;
        end else if (load1) begin
            cnt_next = W'(1);
        end else if (inc) begin
            cnt_next = W'(sat_inc(RD_MAX_W'(cnt), RD_MAX_W'(CNT_MAX)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/run_len_detector.sv
// Run-length detector: flags when the serial stream holds one value for RUN_LEN valid samples.
// Optional rising-edge event counter on out is compiled in with RUNDET_EVT_CNT_EN.
//
//   state   | meaning
//   --------+-------------------------------------------
//   RD_IDLE | no valid sample since reset or clr
//   RD_RUN0 | current run is of 0s, run_cnt is its length
//   RD_RUN1 | current run is of 1s, run_cnt is its length
module run_len_detector
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic             clr,
    output logic             out,
    output logic             out_val,
    output logic [CNT_W-1:0] run_cnt
`ifdef RUNDET_EVT_CNT_EN
   ,output logic [CNT_W-1:0] evt_cnt
`endif
);

    if (RUN_LEN < 2 || RUN_LEN > (2**CNT_W) - 1) begin : g_bad_run_len
        $fatal(1, "run_len_detector: RUN_LEN outside 2..2**CNT_W-1");
    end

    localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

    rd_state_t        state;
    rd_state_t        next_state;
    logic             run_load1;
    logic             run_inc;
    logic [CNT_W-1:0] run_cnt_next;
    logic             next_out;

    always_comb begin
        next_state = state;
        run_load1  = 1'b0;
        run_inc    = 1'b0;
        if (clr) begin
            next_state = RD_IDLE;
        end else if (in_valid) begin
            unique case (state)
                RD_RUN0: begin
                    if (in) begin
                        next_state = RD_RUN1;
                        run_load1  = 1'b1;
                    end else begin
                        run_inc = 1'b1;
                    end
                end
                RD_RUN1: begin
                    if (in) begin
                        run_inc = 1'b1;
                    end else begin
                        next_state = RD_RUN0;
                        run_load1  = 1'b1;
                    end
                end
                default: begin
                    next_state = in ? RD_RUN1 : RD_RUN0;
                    run_load1  = 1'b1;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_run_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .clr      (clr),
        .load1    (run_load1),
        .inc      (run_inc),
        .cnt      (run_cnt),
        .cnt_next (run_cnt_next)
    );

    // Flag follows the count being loaded this edge, so it lands with the same latency.
    assign next_out = (run_cnt_next >= RUN_LEN_C);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RD_IDLE;
            out     <= 1'b0;
            out_val <= 1'b0;
        end else begin
            state   <= next_state;
            out     <= next_out;
            out_val <= (next_state == RD_RUN1);
        end
    end

`ifdef RUNDET_EVT_CNT_EN
    logic             evt_inc;
    logic [CNT_W-1:0] evt_cnt_next;

    assign evt_inc = next_out & ~out;

    sat_counter #(.W(CNT_W)) u_evt_cnt (
        .clk      (clk),
        .rst_n    (reset),
        .clr      (clr),
        .load1    (1'b0),
        .inc      (evt_inc),
        .cnt      (evt_cnt),
        .cnt_next (evt_cnt_next)
    );
`else
    // No event counter in this build; out edges are not tallied.
`endif

endmodule

// File: tb/tb_run_len_detector.sv
// Directed self-checking bench for run_len_detector (RUN_LEN=4, CNT_W=4).
// Event-counter checks are included when RUNDET_EVT_CNT_EN is defined.
module tb_run_len_detector;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in;
    logic       clr;
    logic       out;
    logic       out_val;
    logic [3:0] run_cnt;
`ifdef RUNDET_EVT_CNT_EN
    logic [3:0] evt_cnt;
`endif

    int n_vec;
    int n_err;

    run_len_detector #(.RUN_LEN(4), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in       (in),
        .clr      (clr),
        .out      (out),
        .out_val  (out_val),
        .run_cnt  (run_cnt)
`ifdef RUNDET_EVT_CNT_EN
       ,.evt_cnt  (evt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input int e_out, input int e_val, input int e_cnt);
        chk({tag, ".out"},     int'(out),     e_out);
        chk({tag, ".out_val"}, int'(out_val), e_val);
        chk({tag, ".run_cnt"}, int'(run_cnt), e_cnt);
    endtask

    // One clock: drive on the falling edge, settle past the rising edge.
    task automatic sample(input logic v, input logic b);
        @(negedge clk);
        in_valid = v;
        in       = b;
        clr      = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr(input logic v, input logic b);
        @(negedge clk);
        in_valid = v;
        in       = b;
        clr      = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    // Test 2 stimulus and hand-computed expectations
    logic [7:0] t2_in   = 8'b1110_1111;
    int         t2_cnt[8] = '{1, 2, 3, 1, 1, 2, 3, 4};
    int         t2_val[8] = '{1, 1, 1, 0, 1, 1, 1, 1};
    int         t2_out[8] = '{0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        n_vec    = 0;
        n_err    = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in       = 1'b0;
        clr      = 1'b0;

        // 1: reset state, then four 0s
        repeat (2) @(posedge clk);
        #1;
        chk_outs("rst", 0, 0, 0);
`ifdef RUNDET_EVT_CNT_EN
        chk("rst.evt", int'(evt_cnt), 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            sample(1'b1, 1'b0);
            chk_outs($sformatf("t1[%0d]", i), (i >= 4) ? 1 : 0, 0, i);
        end

        // 2: pattern 1,1,1,0,1,1,1,1
        for (int i = 0; i < 8; i++) begin
            sample(1'b1, t2_in[7-i]);
            chk_outs($sformatf("t2[%0d]", i), t2_out[i], t2_val[i], t2_cnt[i]);
        end

        // 3: 20 ones from IDLE saturate at 15, then a 0
        do_clr(1'b0, 1'b0);
        chk_outs("t3.clr", 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            sample(1'b1, 1'b1);
            if (i == 3 || i == 4 || i == 14 || i == 15 || i == 16 || i == 20)
                chk_outs($sformatf("t3[%0d]", i), (i >= 4) ? 1 : 0, 1, (i > 15) ? 15 : i);
        end
        sample(1'b1, 1'b0);
        chk_outs("t3.drop", 0, 0, 1);

        // 4: three ones, invalid gap with toggling input, then one more one
        do_clr(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sample(1'b1, 1'b1);
        chk_outs("t4.run3", 0, 1, 3);
        for (int i = 0; i < 5; i++) begin
            sample(1'b0, logic'(i % 2));
            chk_outs($sformatf("t4.hold[%0d]", i), 0, 1, 3);
        end
        sample(1'b1, 1'b1);
        chk_outs("t4.fourth", 1, 1, 4);

        // 5: clr beats a simultaneous valid sample; next 1 starts a fresh run
        do_clr(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) sample(1'b1, 1'b1);
        chk_outs("t5.run5", 1, 1, 5);
        do_clr(1'b1, 1'b1);
        chk_outs("t5.clr", 0, 0, 0);
        sample(1'b1, 1'b1);
        chk_outs("t5.fresh", 0, 1, 1);
        sample(1'b1, 1'b1);
        chk_outs("t5.pre_rst", 0, 1, 2);
        // async reset pulse between edges
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_outs("t5.async", 0, 0, 0);
        #1;
        reset = 1'b1;
        sample(1'b1, 1'b1);
        chk_outs("t5.after_rst", 0, 1, 1);

`ifdef RUNDET_EVT_CNT_EN
        // 6: three separate runs of four ones
        do_clr(1'b0, 1'b0);
        chk("t6.clr0", int'(evt_cnt), 0);
        for (int r = 1; r <= 3; r++) begin
            for (int i = 0; i < 4; i++) sample(1'b1, 1'b1);
            chk($sformatf("t6.run%0d", r), int'(evt_cnt), r);
            if (r == 1) begin
                sample(1'b1, 1'b1);
                chk("t6.no_retrig", int'(evt_cnt), 1);
            end
            sample(1'b1, 1'b0);
        end
        chk("t6.total", int'(evt_cnt), 3);
        do_clr(1'b0, 1'b0);
        chk("t6.clr", int'(evt_cnt), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
